// File: rtl/riscv_mult_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_defines
//   Definitions shared by the EX stage and the multiplier arbiter:
//   multiplier operator encodings, the arbiter state type and the
//   latched external command record.
// -----------------------------------------------------------------------------
package riscv_defines;

   localparam int unsigned MULT_OP_W = 3;

   localparam logic [MULT_OP_W-1:0] MUL_MAC32 = 3'b000;
   localparam logic [MULT_OP_W-1:0] MUL_MSU32 = 3'b001;
   localparam logic [MULT_OP_W-1:0] MUL_I     = 3'b010;
   localparam logic [MULT_OP_W-1:0] MUL_IR    = 3'b011;
   localparam logic [MULT_OP_W-1:0] MUL_DOT8  = 3'b100;
   localparam logic [MULT_OP_W-1:0] MUL_DOT16 = 3'b101;
   localparam logic [MULT_OP_W-1:0] MUL_H     = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORE = 2'd1,
      EXT  = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [MULT_OP_W-1:0] op;
      logic [31:0]          a;
      logic [31:0]          b;
      logic [31:0]          c;
   } mult_cmd_t;

endpackage

// File: rtl/riscv_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mult_arbiter_if
//   External (coprocessor/accelerator) multiply port.
//   Request side : ext_req_i, ext_operator_i, ext_op_a/b/c_i  -> ext_gnt_o
//   Response side: ext_rvalid_o, ext_rdata_o                  <- ext_rready_i
//   Signal suffixes are from the arbiter's point of view.
//   slave  : used by the arbiter
//   master : used by the requesting accelerator
// -----------------------------------------------------------------------------
interface riscv_mult_arbiter_if;
   import riscv_defines::*;

   logic                 ext_req_i;
   logic [MULT_OP_W-1:0] ext_operator_i;
   logic [31:0]          ext_op_a_i;
   logic [31:0]          ext_op_b_i;
   logic [31:0]          ext_op_c_i;
   logic                 ext_gnt_o;
   logic                 ext_rvalid_o;
   logic [31:0]          ext_rdata_o;
   logic                 ext_rready_i;

   modport slave (
      input  ext_req_i, ext_operator_i, ext_op_a_i, ext_op_b_i, ext_op_c_i,
      input  ext_rready_i,
      output ext_gnt_o, ext_rvalid_o, ext_rdata_o
   );

   modport master (
      output ext_req_i, ext_operator_i, ext_op_a_i, ext_op_b_i, ext_op_c_i,
      output ext_rready_i,
      input  ext_gnt_o, ext_rvalid_o, ext_rdata_o
   );

endinterface

// File: rtl/riscv_mult_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// riscv_mult_arb_starve_cnt
//   Saturating starvation counter for the external multiply port and the
//   external-wins decision.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ext_req_i     : external request pending
//   ext_gnt_i     : external request granted this cycle (clears the counter)
//   ext_busy_i    : external response still held (blocks a new win)
//   core_req_i    : core requests the multiplier
//   ext_win_o     : external port wins arbitration if the arbiter is idle
//   cnt_o         : current counter value
// -----------------------------------------------------------------------------
module riscv_mult_arb_starve_cnt #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ext_req_i,
   input  logic             ext_gnt_i,
   input  logic             ext_busy_i,
   input  logic             core_req_i,
   output logic             ext_win_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ext_gnt_i) begin
         cnt_d = '0;
      end else if (ext_req_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ext_win_o = ext_req_i & ~ext_busy_i & (~core_req_i | (cnt_q == CNT_MAX));
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/riscv_mult_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mult_arbiter
//   Shares the EX-stage multiplier between the core pipeline and an external
//   accelerator port. Core has priority; the starvation counter bounds the
//   external wait. Core results pass through combinationally, external
//   results are held in a one-entry response buffer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   core_req_i            : core EX holds a multiply
//   core_operator_i       : core multiplier operator
//   core_op_a/b/c_i       : core operands
//   core_ex_ready_i       : EX stage advancing
//   core_ready_o          : core multiply finished this cycle
//   core_result_o         : multiplier result for the core
//   ext                   : external request/response port (slave modport)
//   mult_en_o             : multiplier enable
//   mult_operator_o       : multiplier operator
//   mult_op_a/b/c_o       : multiplier operands
//   mult_ex_ready_o       : multiplier advance
//   mult_result_i         : multiplier result
//   mult_ready_i          : multiplier ready
// -----------------------------------------------------------------------------
module riscv_mult_arbiter
   import riscv_defines::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 core_req_i,
   input  logic [MULT_OP_W-1:0] core_operator_i,
   input  logic [31:0]          core_op_a_i,
   input  logic [31:0]          core_op_b_i,
   input  logic [31:0]          core_op_c_i,
   input  logic                 core_ex_ready_i,
   output logic                 core_ready_o,
   output logic [31:0]          core_result_o,

   riscv_mult_arbiter_if.slave  ext,

   output logic                 mult_en_o,
   output logic [MULT_OP_W-1:0] mult_operator_o,
   output logic [31:0]          mult_op_a_o,
   output logic [31:0]          mult_op_b_o,
   output logic [31:0]          mult_op_c_o,
   output logic                 mult_ex_ready_o,
   input  logic [31:0]          mult_result_i,
   input  logic                 mult_ready_i
);

   arb_state_e state_q;
   mult_cmd_t  ext_cmd_q;
   logic       rvalid_q;
   logic [31:0] rdata_q;

   logic       ext_win;
   logic [CNT_W-1:0] cnt;

   logic       core_own;
   logic       ext_gnt;
   logic       core_ready;
   logic       men;
   logic       mexr;
   mult_cmd_t  mcmd;
   mult_cmd_t  core_cmd;
   mult_cmd_t  ext_cmd_in;

   assign core_cmd   = '{op: core_operator_i, a: core_op_a_i, b: core_op_b_i, c: core_op_c_i};
   assign ext_cmd_in = '{op: ext.ext_operator_i, a: ext.ext_op_a_i, b: ext.ext_op_b_i,
                         c: ext.ext_op_c_i};

   riscv_mult_arb_starve_cnt #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_starve_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .ext_req_i  (ext.ext_req_i),
      .ext_gnt_i  (ext_gnt),
      .ext_busy_i (rvalid_q),
      .core_req_i (core_req_i),
      .ext_win_o  (ext_win),
      .cnt_o      (cnt)
   );

   always_comb begin
      core_own   = 1'b0;
      ext_gnt    = 1'b0;
      core_ready = 1'b0;
      men        = 1'b0;
      mexr       = 1'b0;
      mcmd       = '0;
      case (state_q)
         IDLE: begin
            if (ext_win) begin
               ext_gnt = 1'b1;
            end else if (core_req_i) begin
               core_own   = 1'b1;
               core_ready = mult_ready_i;
            end else begin
               core_ready = 1'b1;
            end
         end
         CORE: begin
            core_own   = 1'b1;
            core_ready = mult_ready_i;
         end
         EXT: begin
            men  = 1'b1;
            mexr = 1'b1;
            mcmd = ext_cmd_q;
         end
         default: ;
      endcase
      if (core_own) begin
         men  = 1'b1;
         mexr = core_ex_ready_i;
         mcmd = core_cmd;
      end
   end

   // Combinational outputs are forced to their reset values while rst_n is
   // low so that reset takes effect on the outputs without waiting for a clock.
   assign mult_en_o        = rst_n & men;
   assign mult_ex_ready_o  = rst_n & mexr;
   assign mult_operator_o  = rst_n ? mcmd.op : '0;
   assign mult_op_a_o      = rst_n ? mcmd.a  : '0;
   assign mult_op_b_o      = rst_n ? mcmd.b  : '0;
   assign mult_op_c_o      = rst_n ? mcmd.c  : '0;
   assign core_ready_o     = rst_n ? core_ready : ~core_req_i;
   assign core_result_o    = (rst_n && core_own) ? mult_result_i : '0;
   assign ext.ext_gnt_o    = rst_n & ext_gnt;
   assign ext.ext_rvalid_o = rvalid_q;
   assign ext.ext_rdata_o  = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ext_cmd_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (rvalid_q && ext.ext_rready_i) begin
            rvalid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (ext_win) begin
                  ext_cmd_q <= ext_cmd_in;
                  state_q   <= EXT;
               end else if (core_req_i && !mult_ready_i) begin
                  state_q <= CORE;
               end
            end
            CORE: begin
               if (mult_ready_i && core_ex_ready_i) begin
                  state_q <= IDLE;
               end
            end
            EXT: begin
               // rvalid_q is known clear here: a grant requires an empty buffer.
               if (mult_ready_i) begin
                  rdata_q  <= mult_result_i;
                  rvalid_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_mult_arbiter
//   Directed vectors for riscv_mult_arbiter. The multiplier is replaced by
//   directly driven mult_result_i / mult_ready_i values.
// -----------------------------------------------------------------------------
module tb_riscv_mult_arbiter;
   import riscv_defines::*;

   localparam logic [2:0] CORE_OP = MUL_MAC32;
   localparam logic [2:0] EXT_OP  = MUL_I;

   typedef struct {
      logic        creq;
      logic        cexr;
      logic [31:0] ca;
      logic [31:0] cb;
      logic        ereq;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        errdy;
      logic        mrdy;
      logic [31:0] mres;
      logic        x_cready;
      logic [31:0] x_cres;
      logic        x_gnt;
      logic        x_rvalid;
      logic [31:0] x_rdata;
      logic        x_men;
      logic        x_mexr;
      logic [2:0]  x_mop;
      logic [31:0] x_opa;
      logic [31:0] x_opb;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        core_req;
   logic [2:0]  core_operator;
   logic [31:0] core_op_a, core_op_b, core_op_c;
   logic        core_ex_ready;
   logic        core_ready;
   logic [31:0] core_result;
   logic        mult_en;
   logic [2:0]  mult_operator;
   logic [31:0] mult_op_a, mult_op_b, mult_op_c;
   logic        mult_ex_ready;
   logic [31:0] mult_result;
   logic        mult_ready;

   int checks;
   int errors;

   riscv_mult_arbiter_if ext_if ();

   riscv_mult_arbiter #(
      .MAX_WAIT (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .core_req_i      (core_req),
      .core_operator_i (core_operator),
      .core_op_a_i     (core_op_a),
      .core_op_b_i     (core_op_b),
      .core_op_c_i     (core_op_c),
      .core_ex_ready_i (core_ex_ready),
      .core_ready_o    (core_ready),
      .core_result_o   (core_result),
      .ext             (ext_if.slave),
      .mult_en_o       (mult_en),
      .mult_operator_o (mult_operator),
      .mult_op_a_o     (mult_op_a),
      .mult_op_b_o     (mult_op_b),
      .mult_op_c_o     (mult_op_c),
      .mult_ex_ready_o (mult_ex_ready),
      .mult_result_i   (mult_result),
      .mult_ready_i    (mult_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   function automatic vec_t mk(
      input logic creq, input logic cexr, input logic [31:0] ca, input logic [31:0] cb,
      input logic ereq, input logic [31:0] ea, input logic [31:0] eb, input logic errdy,
      input logic mrdy, input logic [31:0] mres,
      input logic x_cready, input logic [31:0] x_cres, input logic x_gnt,
      input logic x_rvalid, input logic [31:0] x_rdata, input logic x_men,
      input logic x_mexr, input logic [2:0] x_mop, input logic [31:0] x_opa,
      input logic [31:0] x_opb);
      vec_t v;
      v.creq = creq;  v.cexr = cexr;  v.ca = ca;  v.cb = cb;
      v.ereq = ereq;  v.ea = ea;  v.eb = eb;  v.errdy = errdy;
      v.mrdy = mrdy;  v.mres = mres;
      v.x_cready = x_cready;  v.x_cres = x_cres;  v.x_gnt = x_gnt;
      v.x_rvalid = x_rvalid;  v.x_rdata = x_rdata;  v.x_men = x_men;
      v.x_mexr = x_mexr;  v.x_mop = x_mop;  v.x_opa = x_opa;  v.x_opb = x_opb;
      return v;
   endfunction

   task automatic chk(input string name, input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
      end
   endtask

   task automatic check_outs(input vec_t v, input string tag);
      chk("core_ready_o",    tag, 32'(core_ready),      32'(v.x_cready));
      chk("core_result_o",   tag, core_result,          v.x_cres);
      chk("ext_gnt_o",       tag, 32'(ext_if.ext_gnt_o), 32'(v.x_gnt));
      chk("ext_rvalid_o",    tag, 32'(ext_if.ext_rvalid_o), 32'(v.x_rvalid));
      chk("ext_rdata_o",     tag, ext_if.ext_rdata_o,   v.x_rdata);
      chk("mult_en_o",       tag, 32'(mult_en),         32'(v.x_men));
      chk("mult_ex_ready_o", tag, 32'(mult_ex_ready),   32'(v.x_mexr));
      chk("mult_operator_o", tag, 32'(mult_operator),   32'(v.x_mop));
      chk("mult_op_a_o",     tag, mult_op_a,            v.x_opa);
      chk("mult_op_b_o",     tag, mult_op_b,            v.x_opb);
   endtask

   task automatic drive(input vec_t v);
      core_req             = v.creq;
      core_ex_ready        = v.cexr;
      core_op_a            = v.ca;
      core_op_b            = v.cb;
      ext_if.ext_req_i     = v.ereq;
      ext_if.ext_op_a_i    = v.ea;
      ext_if.ext_op_b_i    = v.eb;
      ext_if.ext_rready_i  = v.errdy;
      mult_ready           = v.mrdy;
      mult_result          = v.mres;
   endtask

   // Drive on the falling edge, check 2 time units later (rising edge is at +5).
   task automatic run(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      #2;
      check_outs(v, tag);
   endtask

   vec_t tbl [16];
   vec_t v;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      core_operator          = CORE_OP;
      core_op_c              = 32'h0;
      ext_if.ext_operator_i  = EXT_OP;
      ext_if.ext_op_c_i      = 32'h0;
      drive(mk(0,1,0,0, 0,0,0,0, 0,0, 1,0,0,0,0, 0,0,0,0,0));

      // core-only, external-only, response hold, then 4-cycle contention
      tbl[0]  = mk(0,1,0,0, 0,0,0,0,             0,0,           1,0,0,0,0,            0,0,0,0,0);
      tbl[1]  = mk(1,1,3,7, 0,0,0,0,             1,21,          1,21,0,0,0,           1,1,CORE_OP,3,7);
      tbl[2]  = mk(0,1,0,0, 1,32'h10000,32'h10,0, 0,0,          0,0,1,0,0,            0,0,0,0,0);
      tbl[3]  = mk(0,1,0,0, 0,0,0,0,             0,0,           0,0,0,0,0,            1,1,EXT_OP,32'h10000,32'h10);
      tbl[4]  = mk(0,1,0,0, 0,0,0,0,             1,32'h100000,  0,0,0,0,0,            1,1,EXT_OP,32'h10000,32'h10);
      tbl[5]  = mk(0,1,0,0, 0,0,0,0,             0,0,           1,0,0,1,32'h100000,   0,0,0,0,0);
      tbl[6]  = mk(0,1,0,0, 0,0,0,0,             0,0,           1,0,0,1,32'h100000,   0,0,0,0,0);
      tbl[7]  = mk(0,1,0,0, 0,0,0,1,             0,0,           1,0,0,1,32'h100000,   0,0,0,0,0);
      tbl[8]  = mk(0,1,0,0, 0,0,0,0,             0,0,           1,0,0,0,32'h100000,   0,0,0,0,0);
      tbl[9]  = mk(1,1,5,6, 1,7,9,0,             1,30,          1,30,0,0,32'h100000,  1,1,CORE_OP,5,6);
      tbl[10] = tbl[9];
      tbl[11] = tbl[9];
      tbl[12] = tbl[9];
      tbl[13] = mk(1,1,5,6, 1,7,9,0,             1,30,          0,0,1,0,32'h100000,   0,0,0,0,0);
      tbl[14] = mk(1,1,5,6, 0,0,0,0,             1,63,          0,0,0,0,32'h100000,   1,1,EXT_OP,7,9);
      tbl[15] = mk(1,1,5,6, 0,0,0,1,             1,30,          1,30,0,1,63,          1,1,CORE_OP,5,6);

      // reset state
      @(negedge clk);
      #2;
      check_outs(tbl[0], "reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run(tbl[i], $sformatf("vec%0d", i));
      end

      // multicycle core while the external request waits; counter saturates
      run(mk(1,0,4,5, 0,0,0,0,        0,0,  0,0,0,0,63, 1,0,CORE_OP,4,5), "mc_start");
      for (int i = 0; i < 4; i++) begin
         run(mk(1,1,4,5, 1,32'h11,2,0, 0,0,  0,0,0,0,63, 1,1,CORE_OP,4,5),
             $sformatf("mc_wait%0d", i));
      end
      run(mk(1,1,4,5, 1,32'h11,2,0, 1,20, 1,20,0,0,63, 1,1,CORE_OP,4,5), "mc_done");
      run(mk(1,1,4,5, 1,32'h11,2,0, 1,20, 0,0,1,0,63,  0,0,0,0,0),        "mc_ext_gnt");
      run(mk(1,1,4,5, 0,0,0,0,      1,32'h22, 0,0,0,0,63, 1,1,EXT_OP,32'h11,2), "mc_ext_mul");

      // backpressure: held response blocks a second grant
      for (int i = 0; i < 3; i++) begin
         run(mk(1,1,4,5, 1,32'h33,3,0, 1,20, 1,20,0,1,32'h22, 1,1,CORE_OP,4,5),
             $sformatf("bp_hold%0d", i));
      end
      run(mk(1,1,4,5, 1,32'h33,3,1, 1,20, 1,20,0,1,32'h22, 1,1,CORE_OP,4,5), "bp_rready");
      run(mk(1,1,4,5, 1,32'h33,3,0, 1,20, 0,0,1,0,32'h22,  0,0,0,0,0),        "bp_gnt2");

      // asynchronous reset in the middle of an external multiply
      run(mk(1,1,4,5, 0,0,0,0, 0,0, 0,0,0,0,32'h22, 1,1,EXT_OP,32'h33,3), "rst_ext");
      #1;
      rst_n = 1'b0;
      #1;
      v = mk(1,1,4,5, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0,0);
      check_outs(v, "rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      run(mk(1,1,2,4, 0,0,0,0, 1,8, 1,8,0,0,0, 1,1,CORE_OP,2,4), "rst_core");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
